mult_div_sequencer: RTL

// Sequences the shared iterative multiply/divide unit on behalf of the main control FSM.

---
 rtl/mult_div_pkg.sv | 33 +++
 rtl/mdu_iter_counter.sv | 35 +++
 rtl/mult_div_sequencer.sv | 111 +++++++++++
 3 files changed

// File: rtl/mult_div_pkg.sv
// Shared definitions for the mult/div sequencer and the main control FSM:
// state encodings, operation codes and the default iteration count.
package mult_div_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4,
        EXC   = 3'd5
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int unsigned ITER_DEFAULT  = 32;
    localparam int unsigned CNT_W_DEFAULT = 6;

    typedef struct packed {
        logic md_load;
        logic mult_op;
        logic div_op;
        logic hi_we;
        logic lo_we;
        logic mux_hi;
        logic mux_lo;
        logic busy;
        logic done;
        logic div_zero_exc;
    } seq_out_t;

endpackage

// File: rtl/mdu_iter_counter.sv
// Loadable down-counter with a zero flag; saturates at zero rather than wrapping.
module mdu_iter_counter #(
    parameter int unsigned CNT_W  = 6,
    parameter int unsigned RELOAD = 31
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic dec_i,
    output logic zero_o
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = CNT_W'(RELOAD);
        end else if (dec_i && (count_q != '0)) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= CNT_W'(RELOAD);
        end else begin
            count_q <= count_d;
        end
    end

    assign zero_o = (count_q == '0);

endmodule

// File: rtl/mult_div_sequencer.sv
// Sequences the shared iterative multiply/divide unit: load, ITER steps, HI/LO write, done.
// Divide-by-zero is reported as a one-cycle exception without touching the unit.
module mult_div_sequencer
    import mult_div_pkg::*;
#(
    parameter int unsigned ITER  = ITER_DEFAULT,
    parameter int unsigned CNT_W = CNT_W_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic start_mult,
    input  logic start_div,
    input  logic divisor_zero,
    output logic md_load,
    output logic MULT_OP,
    output logic DIV_OP,
    output logic Reg_HI_Write,
    output logic Reg_Lo_Write,
    output logic MuxHi,
    output logic MuxLo,
    output logic busy,
    output logic done,
    output logic div_zero_exc
);

    state_e   state_q;
    logic     op_q;
    seq_out_t outs_q;
    logic     cnt_zero;

    mdu_iter_counter #(
        .CNT_W  (CNT_W),
        .RELOAD (ITER - 1)
    ) u_iter_counter (
        .clk_i  (clock),
        .rst_i  (reset),
        .load_i (state_q == LOAD),
        .dec_i  (state_q == RUN),
        .zero_o (cnt_zero)
    );

    // Outputs are registered as the Moore decode of the state being entered,
    // so each one lines up exactly with the cycle its state is occupied.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= OP_MULT;
            outs_q  <= '0;
        end else begin
            outs_q <= '0;
            case (state_q)
                IDLE: begin
                    if (start_mult) begin
                        op_q           <= OP_MULT;
                        state_q        <= LOAD;
                        outs_q.md_load <= 1'b1;
                        outs_q.busy    <= 1'b1;
                    end else if (start_div && divisor_zero) begin
                        state_q             <= EXC;
                        outs_q.div_zero_exc <= 1'b1;
                        outs_q.busy         <= 1'b1;
                    end else if (start_div) begin
                        op_q           <= OP_DIV;
                        state_q        <= LOAD;
                        outs_q.md_load <= 1'b1;
                        outs_q.busy    <= 1'b1;
                    end
                end
                LOAD: begin
                    state_q        <= RUN;
                    outs_q.mult_op <= (op_q == OP_MULT);
                    outs_q.div_op  <= (op_q == OP_DIV);
                    outs_q.busy    <= 1'b1;
                end
                RUN: begin
                    outs_q.busy <= 1'b1;
                    if (cnt_zero) begin
                        state_q       <= WRITE;
                        outs_q.hi_we  <= 1'b1;
                        outs_q.lo_we  <= 1'b1;
                        outs_q.mux_hi <= (op_q == OP_DIV);
                        outs_q.mux_lo <= (op_q == OP_DIV);
                    end else begin
                        outs_q.mult_op <= (op_q == OP_MULT);
                        outs_q.div_op  <= (op_q == OP_DIV);
                    end
                end
                WRITE: begin
                    state_q     <= DONE;
                    outs_q.done <= 1'b1;
                    outs_q.busy <= 1'b1;
                end
                DONE:    state_q <= IDLE;
                EXC:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md_load      = outs_q.md_load;
    assign MULT_OP      = outs_q.mult_op;
    assign DIV_OP       = outs_q.div_op;
    assign Reg_HI_Write = outs_q.hi_we;
    assign Reg_Lo_Write = outs_q.lo_we;
    assign MuxHi        = outs_q.mux_hi;
    assign MuxLo        = outs_q.mux_lo;
    assign busy         = outs_q.busy;
    assign done         = outs_q.done;
    assign div_zero_exc = outs_q.div_zero_exc;

endmodule
